uart_hex_display_ctrl: RTL
==========================

// Module: uart_hex_display_ctrl
// PURPOSE
//  Controller between the UART receiver and one shared seven_seg_decoder driving a
//  NUM_DIGITS multiplexed display. Parses received ASCII hex characters into a staging
//  buffer, commits them to a display buffer on end-of-line, and time-multiplexes the
//  digits onto the single decoder with a blanking guard between digits.
// PARAMETERS
//  CLK_FREQ      12000000  clock frequency, Hz
//  REFRESH_HZ    250       full-frame refresh rate, Hz
//  NUM_DIGITS    4         number of display digits, 2..8
//  GUARD_CYCLES  120       blank cycles at start of each digit slot; < SLOT_CYCLES
//  (derived) SLOT_CYCLES = CLK_FREQ/(REFRESH_HZ*NUM_DIGITS); integer division, must be >= 2
// PORTS
//  clk       in   1            system clock
//  rst       in   1            asynchronous reset, active-high
//  rx_data   in   8            received byte, valid when rx_done=1
//  rx_done   in   1            one-cycle strobe from uart_rx
//  hex_out   out  4            nibble to shared seven_seg_decoder .bin
//  blank     out  1            1 = segments must be forced off
//  digit_en  out  NUM_DIGITS   one-hot digit enable, active-high; bit 0 = rightmost digit
//  err       out  1            sticky: invalid character received
// BEHAVIOUR
//  Reset: display and staging buffers 0, stage_cnt 0, err 0, digit_en 0, hex_out 0,
//   blank 1, scan FSM in S_GUARD for digit 0 with slot counter 0.
//  Parser (acts only on the cycle rx_done=1; all updates registered, visible next cycle):
//   '0'-'9','A'-'F','a'-'f' -> staging shifts left one nibble, new value in digit 0;
//     oldest nibble discarded; stage_cnt increments, saturates at NUM_DIGITS.
//   0x0D or 0x0A -> if stage_cnt>0: display <= staging, staging <= 0, stage_cnt <= 0,
//     err <= 0. If stage_cnt==0: no change (so CR+LF commits once).
//   0x1B (ESC) -> staging <= 0, stage_cnt <= 0, err <= 0; display unchanged.
//   any other byte -> err <= 1; buffers unchanged.
//  Scan FSM, one slot per digit, SLOT_CYCLES cycles each, counter 0..SLOT_CYCLES-1:
//   S_GUARD (count < GUARD_CYCLES): digit_en=0, blank=1.
//   S_DRIVE (count >= GUARD_CYCLES): digit_en one-hot for current digit, blank=0 unless
//     the optional-feature rule blanks it; hex_out = nibble latched on the S_GUARD->S_DRIVE
//     transition (a commit mid-slot never changes the digit being shown).
//   At count == SLOT_CYCLES-1: count <= 0, digit index wraps NUM_DIGITS-1 -> 0, S_GUARD.
//  GUARD_CYCLES=0: S_GUARD never entered; latching occurs on the slot's first cycle.
//  rx_done concurrent with any scan state: both proceed independently, no stalls.
//  rst asserted at any time: immediate return to reset values; partial staging lost.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: in S_DRIVE, digit i>0 has blank=1 (digit_en still
//   asserted) when it and all higher displayed digits are 0; digit 0 never blanked.
//  Not defined: every digit displayed, leading zeros shown.
// STRUCTURE
//  Package uart_disp_pkg: ASCII constants (CR, LF, ESC, '0','9','A','F','a','f'),
//   scan state enum {S_GUARD, S_DRIVE}, function ascii_to_nibble returning {valid, nibble}.
//  Sub-module digit_scan_sched: slot counter, digit index, scan FSM, digit_en/blank;
//   parser and buffers stay in this module.
// TESTING  (bench params: CLK_FREQ=4000, REFRESH_HZ=100, NUM_DIGITS=4, GUARD_CYCLES=2
//   -> SLOT_CYCLES=10)
//  1 Reset, no input -> digit_en cycles 0001,0010,0100,1000 each 8 cycles after 2 blank;
//    hex_out=0, frame period 40 cycles; blank=1 whenever digit_en=0.
//  2 Send "1a3F",CR -> display digits 3..0 = 1,A,3,F; err=0; next frame shows them.
//  3 Send "123456",LF -> display = 3,4,5,6; then LF alone -> display unchanged.
//  4 Send "12",'G',"3",CR -> err=1 after 'G', display = 0,1,2,3 and err=0 after CR;
//    "45",ESC,CR -> display unchanged, err=0.
//  5 Commit "9999" timed to land mid-S_DRIVE of digit 1 -> digit 1 keeps old nibble until
//    its slot ends; next slot of digit 1 shows 9.
//  6 LEADING_ZERO_BLANK_EN, commit "0050" -> digits 3,2 blank=1 in S_DRIVE, digits 1,0
//    show 5,0; commit "0000" -> only digit 0 unblanked; without macro all four shown.
//  Also: rst pulse mid-slot -> all outputs at reset values next edge, scan restarts digit 0.

Source files
------------

// File: rtl/uart_disp_pkg.sv
// rtl/uart_disp_pkg.sv - ASCII constants, scan state enum and hex character decode
package uart_disp_pkg;

   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_ESC  = 8'h1B;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_9    = 8'h39;
   localparam logic [7:0] ASCII_UC_A = 8'h41;
   localparam logic [7:0] ASCII_UC_F = 8'h46;
   localparam logic [7:0] ASCII_LC_A = 8'h61;
   localparam logic [7:0] ASCII_LC_F = 8'h66;

   typedef enum logic {S_GUARD, S_DRIVE} scan_state_t;

   // Returns {valid, nibble}; nibble is 0 when the byte is not a hex digit.
   function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
      logic [7:0] d;
      d = 8'h00;
      ascii_to_nibble = 5'b0_0000;
      if (c >= ASCII_0 && c <= ASCII_9) begin
         d = c - ASCII_0;
         ascii_to_nibble = {1'b1, d[3:0]};
      end else if (c >= ASCII_UC_A && c <= ASCII_UC_F) begin
         d = c - ASCII_UC_A + 8'd10;
         ascii_to_nibble = {1'b1, d[3:0]};
      end else if (c >= ASCII_LC_A && c <= ASCII_LC_F) begin
         d = c - ASCII_LC_A + 8'd10;
         ascii_to_nibble = {1'b1, d[3:0]};
      end
   endfunction

endpackage

// File: rtl/digit_scan_sched.sv
// rtl/digit_scan_sched.sv - per-digit slot timer and guard/drive scan FSM
module digit_scan_sched
   import uart_disp_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 3000,
   parameter int GUARD_CYCLES = 120,
   localparam int IW          = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  blank,
   output logic                  latch,
   output logic [IW-1:0]         latch_idx
);

   localparam int CNT_W = $clog2(SLOT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
   localparam logic [IW-1:0]    IDX_LAST  = IW'(NUM_DIGITS - 1);

   scan_state_t      state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [IW-1:0]    idx, idx_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_GUARD;
         count <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         idx   <= idx_nxt;
      end
   end

   // The nibble is captured on the edge that enters S_DRIVE, either from the
   // guard phase or straight from the previous slot when there is no guard.
   always_comb begin
      count_nxt = count + CNT_W'(1);
      idx_nxt   = idx;
      if (count == CNT_LAST) begin
         count_nxt = '0;
         idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      state_nxt = (count_nxt < CNT_GUARD) ? S_GUARD : S_DRIVE;
      latch     = (state_nxt == S_DRIVE) && ((state == S_GUARD) || (count == CNT_LAST));
      latch_idx = idx_nxt;
      digit_en  = '0;
      blank     = 1'b1;
      if (state == S_DRIVE) begin
         digit_en = NUM_DIGITS'(1) << idx;
         blank    = 1'b0;
      end
   end

endmodule

// File: rtl/uart_hex_display_ctrl.sv
// rtl/uart_hex_display_ctrl.sv - UART hex line parser driving a multiplexed display; LEADING_ZERO_BLANK_EN blanks leading zeros
module uart_hex_display_ctrl
   import uart_disp_pkg::*;
#(
   parameter int CLK_FREQ     = 12000000,
   parameter int REFRESH_HZ   = 250,
   parameter int NUM_DIGITS   = 4,
   parameter int GUARD_CYCLES = 120
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_done,
   output logic [3:0]            hex_out,
   output logic                  blank,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  err
);

   localparam int SLOT_CYCLES = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
   localparam int DW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_MAX = CW'(NUM_DIGITS);

   logic [DW-1:0] display, staging;
   logic [CW-1:0] stage_cnt;
   logic [4:0]    rx_nib;
   logic          scan_blank, latch;
   logic [IW-1:0] latch_idx;

   assign rx_nib = ascii_to_nibble(rx_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         display   <= '0;
         staging   <= '0;
         stage_cnt <= '0;
         err       <= 1'b0;
      end else if (rx_done) begin
         if (rx_nib[4]) begin
            staging <= {staging[DW-5:0], rx_nib[3:0]};
            if (stage_cnt != CNT_MAX)
               stage_cnt <= stage_cnt + CW'(1);
         end else if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
            // An empty line is ignored so a CR+LF pair commits only once.
            if (stage_cnt != '0) begin
               display   <= staging;
               staging   <= '0;
               stage_cnt <= '0;
               err       <= 1'b0;
            end
         end else if (rx_data == ASCII_ESC) begin
            staging   <= '0;
            stage_cnt <= '0;
            err       <= 1'b0;
         end else begin
            err <= 1'b1;
         end
      end
   end

   digit_scan_sched #(
      .NUM_DIGITS   (NUM_DIGITS),
      .SLOT_CYCLES  (SLOT_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_sched (
      .clk       (clk),
      .rst       (rst),
      .digit_en  (digit_en),
      .blank     (scan_blank),
      .latch     (latch),
      .latch_idx (latch_idx)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_vec;
   logic                  zero_above;
   logic                  lz_q;

   // lz_vec[i]: digit i and every digit above it are zero; digit 0 is always shown.
   always_comb begin
      lz_vec     = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (display[4*i +: 4] == 4'h0);
         lz_vec[i]  = (i != 0) && zero_above;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hex_out <= 4'h0;
         lz_q    <= 1'b0;
      end else if (latch) begin
         hex_out <= display[4*int'(latch_idx) +: 4];
         lz_q    <= lz_vec[latch_idx];
      end
   end

   assign blank = scan_blank | lz_q;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hex_out <= 4'h0;
      else if (latch)
         hex_out <= display[4*int'(latch_idx) +: 4];
   end

   assign blank = scan_blank;
`endif

endmodule
